// File: rtl/cpu7_exu_ecldstpipe.sv
// cpu7_exu_ecldstpipe: carries destination register / write enable through
// E, M and W for the operand bypass network, and raises the decode interlock
// for load-use hazards and for the single outstanding long-latency divide.
//
// Long-op position (lo_pos):
//   state  | meaning
//   POS_E  | divide currently in E (cancellable by flush)
//   POS_M  | divide currently in M (cancellable by flush)
//   POS_W  | divide in W, committed
//   POS_C  | divide past W (or idle), waiting for div_done on the late port
module cpu7_exu_ecldstpipe (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid_d,
  input  logic [4:0] rd_d,
  input  logic       wen_d,
  input  logic       load_d,
  input  logic       div_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       rs1_en_d,
  input  logic       rs2_en_d,
  input  logic       hold,
  input  logic       flush,
  input  logic       div_done,
  output logic [4:0] rd_m,
  output logic       wen_m,
  output logic [4:0] rd_w,
  output logic       wen_w,
  output logic       stall_d,
  output logic       div_cancel
);

  typedef enum logic [1:0] {
    POS_E = 2'd0,
    POS_M = 2'd1,
    POS_W = 2'd2,
    POS_C = 2'd3
  } lo_pos_t;

  logic       e_valid_q, e_valid_d;
  logic [4:0] e_rd_q,    e_rd_d;
  logic       e_wen_q,   e_wen_d;
  logic       e_load_q,  e_load_d;

  logic       m_valid_q, m_valid_d;
  logic [4:0] m_rd_q,    m_rd_d;
  logic       m_wen_q,   m_wen_d;
  logic       m_load_q,  m_load_d;

  logic       w_valid_q, w_valid_d;
  logic [4:0] w_rd_q,    w_rd_d;
  logic       w_wen_q,   w_wen_d;
  logic       w_load_q,  w_load_d;

  logic       lo_busy_q, lo_busy_d;
  logic [4:0] lo_rd_q,   lo_rd_d;
  lo_pos_t    lo_pos_q,  lo_pos_d;

  logic load_use;
  logic div_hazard;
  logic div_set;

  // Decode interlock: load-use against E, and any dependence on the pending divide.
  always_comb begin
    load_use = e_valid_q & e_load_q & e_wen_q & (e_rd_q != 5'd0) &
               ((rs1_en_d & (rs1_d == e_rd_q)) | (rs2_en_d & (rs2_d == e_rd_q)));
    div_hazard = lo_busy_q &
                 (div_d |
                  ((lo_rd_q != 5'd0) &
                   ((rs1_en_d & (rs1_d == lo_rd_q)) | (rs2_en_d & (rs2_d == lo_rd_q)))) |
                  (wen_d & (rd_d == lo_rd_q)));
    stall_d    = valid_d & (load_use | div_hazard);
    div_cancel = flush & lo_busy_q & ((lo_pos_q == POS_E) | (lo_pos_q == POS_M));
    div_set    = ~flush & ~hold & valid_d & ~stall_d & div_d;
  end

  // Next-state for stage registers and the divide scoreboard.
  always_comb begin
    e_valid_d = e_valid_q;
    e_rd_d    = e_rd_q;
    e_wen_d   = e_wen_q;
    e_load_d  = e_load_q;
    m_valid_d = m_valid_q;
    m_rd_d    = m_rd_q;
    m_wen_d   = m_wen_q;
    m_load_d  = m_load_q;
    w_valid_d = w_valid_q;
    w_rd_d    = w_rd_q;
    w_wen_d   = w_wen_q;
    w_load_d  = w_load_q;
    lo_busy_d = lo_busy_q;
    lo_rd_d   = lo_rd_q;
    lo_pos_d  = lo_pos_q;

    if (flush) begin
      // E and M are killed; what was in W has left, and M's occupant never arrives.
      e_valid_d = 1'b0;
      e_rd_d    = 5'd0;
      e_wen_d   = 1'b0;
      e_load_d  = 1'b0;
      m_valid_d = 1'b0;
      m_rd_d    = 5'd0;
      m_wen_d   = 1'b0;
      m_load_d  = 1'b0;
      w_valid_d = 1'b0;
      w_rd_d    = 5'd0;
      w_wen_d   = 1'b0;
      w_load_d  = 1'b0;
      if (div_cancel) lo_busy_d = 1'b0;
      lo_pos_d = POS_C;
    end else if (!hold) begin
      w_valid_d = m_valid_q;
      w_rd_d    = m_rd_q;
      w_wen_d   = m_wen_q;
      w_load_d  = m_load_q;
      m_valid_d = e_valid_q;
      m_rd_d    = e_rd_q;
      m_wen_d   = e_wen_q;
      m_load_d  = e_load_q;
      if (valid_d && !stall_d) begin
        e_valid_d = 1'b1;
        e_rd_d    = rd_d;
        // Divide results return on the late port, never through M/W bypass.
        e_wen_d   = wen_d & ~div_d;
        e_load_d  = load_d;
      end else begin
        e_valid_d = 1'b0;
        e_rd_d    = 5'd0;
        e_wen_d   = 1'b0;
        e_load_d  = 1'b0;
      end
      case (lo_pos_q)
        POS_E:   lo_pos_d = POS_M;
        POS_M:   lo_pos_d = POS_W;
        default: lo_pos_d = POS_C;
      endcase
    end

    if (div_done) lo_busy_d = 1'b0;

    // A new divide entering E outranks a completion in the same cycle.
    if (div_set) begin
      lo_busy_d = 1'b1;
      lo_rd_d   = rd_d;
      lo_pos_d  = POS_E;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_valid_q <= 1'b0;
      e_rd_q    <= 5'd0;
      e_wen_q   <= 1'b0;
      e_load_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_rd_q    <= 5'd0;
      m_wen_q   <= 1'b0;
      m_load_q  <= 1'b0;
      w_valid_q <= 1'b0;
      w_rd_q    <= 5'd0;
      w_wen_q   <= 1'b0;
      w_load_q  <= 1'b0;
      lo_busy_q <= 1'b0;
      lo_rd_q   <= 5'd0;
      lo_pos_q  <= POS_C;
    end else begin
      e_valid_q <= e_valid_d;
      e_rd_q    <= e_rd_d;
      e_wen_q   <= e_wen_d;
      e_load_q  <= e_load_d;
      m_valid_q <= m_valid_d;
      m_rd_q    <= m_rd_d;
      m_wen_q   <= m_wen_d;
      m_load_q  <= m_load_d;
      w_valid_q <= w_valid_d;
      w_rd_q    <= w_rd_d;
      w_wen_q   <= w_wen_d;
      w_load_q  <= w_load_d;
      lo_busy_q <= lo_busy_d;
      lo_rd_q   <= lo_rd_d;
      lo_pos_q  <= lo_pos_d;
    end
  end

  // Bypass-facing outputs; rd is raw, r0 filtering happens at the consumer.
  always_comb begin
    rd_m  = m_rd_q;
    wen_m = m_valid_q & m_wen_q;
    rd_w  = w_rd_q;
    wen_w = w_valid_q & w_wen_q;
  end

  // W load flag is carried for symmetry with E/M but has no consumer here.
  logic unused_w_load;
  assign unused_w_load = w_load_q;

endmodule

// File: tb/tb_cpu7_exu_ecldstpipe.sv
// Directed bench for cpu7_exu_ecldstpipe: bypass timing, load-use and
// divide interlocks, flush/cancel, hold and reset behaviour.
module tb_cpu7_exu_ecldstpipe;

  logic       clk = 1'b0;
  logic       resetn;
  logic       valid_d;
  logic [4:0] rd_d;
  logic       wen_d;
  logic       load_d;
  logic       div_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic       rs1_en_d;
  logic       rs2_en_d;
  logic       hold;
  logic       flush;
  logic       div_done;
  logic [4:0] rd_m;
  logic       wen_m;
  logic [4:0] rd_w;
  logic       wen_w;
  logic       stall_d;
  logic       div_cancel;

  int n_chk  = 0;
  int n_pass = 0;

  cpu7_exu_ecldstpipe dut (
    .clk        (clk),
    .resetn     (resetn),
    .valid_d    (valid_d),
    .rd_d       (rd_d),
    .wen_d      (wen_d),
    .load_d     (load_d),
    .div_d      (div_d),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_en_d   (rs1_en_d),
    .rs2_en_d   (rs2_en_d),
    .hold       (hold),
    .flush      (flush),
    .div_done   (div_done),
    .rd_m       (rd_m),
    .wen_m      (wen_m),
    .rd_w       (rd_w),
    .wen_w      (wen_w),
    .stall_d    (stall_d),
    .div_cancel (div_cancel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic dv, input logic [4:0] s1, input logic e1,
                       input logic [4:0] s2, input logic e2);
    valid_d  = 1'b1;
    rd_d     = rd;
    wen_d    = wen;
    load_d   = ld;
    div_d    = dv;
    rs1_d    = s1;
    rs1_en_d = e1;
    rs2_d    = s2;
    rs2_en_d = e2;
    #1;
  endtask

  task automatic idle();
    valid_d  = 1'b0;
    rd_d     = 5'd0;
    wen_d    = 1'b0;
    load_d   = 1'b0;
    div_d    = 1'b0;
    rs1_d    = 5'd0;
    rs1_en_d = 1'b0;
    rs2_d    = 5'd0;
    rs2_en_d = 1'b0;
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    hold     = 1'b0;
    flush    = 1'b0;
    div_done = 1'b0;
    idle();
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("reset_rd_m", 8'(rd_m), 8'd0);
    chk("reset_wen_m", 8'(wen_m), 8'd0);
    chk("reset_rd_w", 8'(rd_w), 8'd0);
    chk("reset_wen_w", 8'(wen_w), 8'd0);
    chk("reset_stall", 8'(stall_d), 8'd0);
    chk("reset_cancel", 8'(div_cancel), 8'd0);

    // Back-to-back ALU ops r5 then r6
    issue(5'd5, 1, 0, 0, 5'd1, 1, 5'd2, 1);
    chk("alu_r5_stall", 8'(stall_d), 8'd0);
    tick();
    issue(5'd6, 1, 0, 0, 5'd3, 1, 5'd4, 1);
    chk("alu_r6_stall", 8'(stall_d), 8'd0);
    tick();
    idle();
    chk("alu_t2_rd_m", 8'(rd_m), 8'd5);
    chk("alu_t2_wen_m", 8'(wen_m), 8'd1);
    tick();
    chk("alu_t3_rd_w", 8'(rd_w), 8'd5);
    chk("alu_t3_wen_w", 8'(wen_w), 8'd1);
    chk("alu_t3_rd_m", 8'(rd_m), 8'd6);
    chk("alu_t3_wen_m", 8'(wen_m), 8'd1);
    tick();
    chk("alu_t4_rd_w", 8'(rd_w), 8'd6);
    tick();
    tick();

    // Load r7 then add r8 <- r7
    issue(5'd7, 1, 1, 0, 5'd1, 1, 5'd0, 0);
    chk("ld_issue_stall", 8'(stall_d), 8'd0);
    tick();
    issue(5'd8, 1, 0, 0, 5'd7, 1, 5'd2, 1);
    chk("ld_use_stall", 8'(stall_d), 8'd1);
    tick();
    chk("ld_use_release", 8'(stall_d), 8'd0);
    chk("ld_in_m_rd", 8'(rd_m), 8'd7);
    chk("ld_in_m_wen", 8'(wen_m), 8'd1);
    tick();
    idle();
    chk("ld_bubble_wen_m", 8'(wen_m), 8'd0);
    chk("ld_in_w_rd", 8'(rd_w), 8'd7);
    tick();
    chk("add_in_m_rd", 8'(rd_m), 8'd8);
    chk("add_in_m_wen", 8'(wen_m), 8'd1);
    // Load to r0 never interlocks
    issue(5'd0, 1, 1, 0, 5'd1, 1, 5'd0, 0);
    tick();
    issue(5'd4, 1, 0, 0, 5'd0, 1, 5'd0, 1);
    chk("ld_r0_no_stall", 8'(stall_d), 8'd0);
    tick();
    idle();
    tick();
    tick();
    tick();

    // Divide r9 with dependent reader, independent op, second divide
    issue(5'd9, 1, 0, 1, 5'd1, 1, 5'd2, 1);
    chk("div_issue_stall", 8'(stall_d), 8'd0);
    tick();
    issue(5'd10, 1, 0, 0, 5'd9, 1, 5'd0, 0);
    chk("div_rd_e_stall", 8'(stall_d), 8'd1);
    tick();
    chk("div_rd_m_stall", 8'(stall_d), 8'd1);
    chk("div_in_m_rd", 8'(rd_m), 8'd9);
    chk("div_in_m_wen", 8'(wen_m), 8'd0);
    tick();
    chk("div_in_w_wen", 8'(wen_w), 8'd0);
    issue(5'd3, 1, 0, 0, 5'd3, 1, 5'd0, 0);
    chk("div_indep_stall", 8'(stall_d), 8'd0);
    tick();
    issue(5'd11, 1, 0, 1, 5'd1, 1, 5'd2, 1);
    chk("div_second_stall", 8'(stall_d), 8'd1);
    issue(5'd10, 1, 0, 0, 5'd0, 0, 5'd9, 1);
    div_done = 1'b1;
    #1;
    chk("div_done_cycle_stall", 8'(stall_d), 8'd1);
    tick();
    div_done = 1'b0;
    #1;
    chk("div_after_done_stall", 8'(stall_d), 8'd0);
    tick();
    idle();
    tick();
    tick();
    tick();

    // Divide flushed in M is cancelled
    issue(5'd9, 1, 0, 1, 5'd1, 1, 5'd2, 1);
    tick();
    idle();
    tick();
    flush = 1'b1;
    #1;
    chk("cancel_m", 8'(div_cancel), 8'd1);
    tick();
    flush = 1'b0;
    issue(5'd10, 1, 0, 0, 5'd9, 1, 5'd0, 0);
    chk("cancel_m_cleared", 8'(stall_d), 8'd0);
    chk("cancel_m_off", 8'(div_cancel), 8'd0);
    chk("cancel_m_wen_m", 8'(wen_m), 8'd0);
    tick();
    idle();
    tick();
    tick();
    tick();

    // Divide at W survives the flush
    issue(5'd9, 1, 0, 1, 5'd1, 1, 5'd2, 1);
    tick();
    idle();
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("cancel_w", 8'(div_cancel), 8'd0);
    tick();
    flush = 1'b0;
    issue(5'd10, 1, 0, 0, 5'd9, 1, 5'd0, 0);
    chk("survive_stall_0", 8'(stall_d), 8'd1);
    tick();
    chk("survive_stall_1", 8'(stall_d), 8'd1);
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    #1;
    chk("survive_done", 8'(stall_d), 8'd0);
    idle();
    tick();
    tick();
    tick();

    // Hold with E/M/W full, then flush under hold
    issue(5'd1, 1, 0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    issue(5'd2, 1, 0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    issue(5'd3, 1, 0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    idle();
    chk("full_rd_m", 8'(rd_m), 8'd2);
    chk("full_rd_w", 8'(rd_w), 8'd1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd_m", 8'(rd_m), 8'd2);
      chk("hold_wen_m", 8'(wen_m), 8'd1);
      chk("hold_rd_w", 8'(rd_w), 8'd1);
      chk("hold_wen_w", 8'(wen_w), 8'd1);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("hold_flush_wen_m", 8'(wen_m), 8'd0);
    hold = 1'b0;
    tick();
    chk("hold_flush_wen_w", 8'(wen_w), 8'd0);
    tick();

    // Reset mid-divide
    issue(5'd4, 1, 0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    issue(5'd9, 1, 0, 1, 5'd1, 1, 5'd2, 1);
    tick();
    issue(5'd12, 1, 0, 0, 5'd0, 0, 5'd0, 0);
    tick();
    idle();
    chk("pre_rst_wen_w", 8'(wen_w), 8'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("rst_rd_m", 8'(rd_m), 8'd0);
    chk("rst_wen_m", 8'(wen_m), 8'd0);
    chk("rst_rd_w", 8'(rd_w), 8'd0);
    chk("rst_wen_w", 8'(wen_w), 8'd0);
    chk("rst_cancel", 8'(div_cancel), 8'd0);
    issue(5'd10, 1, 0, 0, 5'd9, 1, 5'd0, 0);
    chk("rst_reader_stall", 8'(stall_d), 8'd0);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
